// File: rtl/vram_loader.sv
// vram_loader: UART packet loader writing 6-bit VRAM words (define VRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte)
module vram_loader #(
  parameter int VRAM_DEPTH = 30000,
  parameter int TIMEOUT_CYCLES = 1066667
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        rx_ack,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [5:0]  wr_data,
  output logic        busy,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [1:0]  err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, PAYLOAD, FILL_VAL, FILL
`ifdef VRAM_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;
  state_t state;
  logic is_fill;
  logic [14:0] addr;
  logic [15:0] len;
  logic [5:0] val;
  logic [TW-1:0] tmo;
`ifdef VRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif
  logic accepting, tmo_on, tmo_hit, addr_bad, fin;
  logic [14:0] addr_nx;
  assign busy = state != IDLE;
  assign accepting = !(state == FILL || (state == PAYLOAD && len == '0));
  assign tmo_on = !(state == IDLE || state == FILL);
  assign tmo_hit = tmo_on && !rx_ack && tmo == TW'(TIMEOUT_CYCLES);
  assign addr_bad = 32'(addr) >= VRAM_DEPTH;
  assign addr_nx = (32'(addr) == VRAM_DEPTH - 1) ? '0 : addr + 15'd1;
  assign fin = (state == LEN_L && rx_ack && !addr_bad && {len[15:8], rx_data} == 16'd0) ||
               ((state == PAYLOAD || state == FILL) && len == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rx_ack <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      pkt_done <= 1'b0;
      pkt_err <= 1'b0;
      err_code <= '0;
      is_fill <= 1'b0;
      addr <= '0;
      len <= '0;
      val <= '0;
      tmo <= '0;
`ifdef VRAM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      rx_ack <= accepting && rx_ready && !rx_ack && !tmo_hit;
      wr_en <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err <= 1'b0;
      tmo <= (rx_ack || !tmo_on) ? '0 : tmo + TW'(1);
`ifdef VRAM_LOADER_CHECKSUM_EN
      csum <= (state == IDLE) ? '0 : (rx_ack && state != CSUM) ? csum ^ rx_data : csum;
`endif
      if (tmo_hit) begin
        state <= IDLE;
        pkt_err <= 1'b1;
        err_code <= 2'd3;
      end else if (rx_ack)
        case (state)
          IDLE: state <= (rx_data == 8'hA5) ? CMD : IDLE;
          CMD: begin
            is_fill <= rx_data[1];
            state <= (rx_data == 8'h01 || rx_data == 8'h02) ? ADDR_H : IDLE;
            if (rx_data != 8'h01 && rx_data != 8'h02) begin
              pkt_err <= 1'b1;
              err_code <= 2'd1;
            end
          end
          ADDR_H: begin
            addr[14:8] <= rx_data[6:0];
            state <= ADDR_L;
          end
          ADDR_L: begin
            addr[7:0] <= rx_data;
            state <= LEN_H;
          end
          LEN_H: begin
            len[15:8] <= rx_data;
            state <= LEN_L;
          end
          LEN_L: begin
            len[7:0] <= rx_data;
            state <= addr_bad ? IDLE : is_fill ? FILL_VAL : PAYLOAD;
            if (addr_bad) begin
              pkt_err <= 1'b1;
              err_code <= 2'd2;
            end
          end
          PAYLOAD: begin
            wr_en <= 1'b1;
            wr_addr <= addr;
            wr_data <= rx_data[5:0];
            addr <= addr_nx;
            len <= len - 16'd1;
          end
          FILL_VAL: begin
            val <= rx_data[5:0];
            state <= FILL;
          end
`ifdef VRAM_LOADER_CHECKSUM_EN
          CSUM: begin
            state <= IDLE;
            pkt_done <= rx_data == csum;
            pkt_err <= rx_data != csum;
            if (rx_data != csum) err_code <= 2'd3;
          end
`endif
          default: ;
        endcase
      if (state == FILL && len != '0) begin
        wr_en <= 1'b1;
        wr_addr <= addr;
        wr_data <= val;
        addr <= addr_nx;
        len <= len - 16'd1;
      end
      if (fin) begin
`ifdef VRAM_LOADER_CHECKSUM_EN
        state <= CSUM;
`else
        state <= IDLE;
        pkt_done <= 1'b1;
`endif
      end
    end
endmodule

// File: tb/tb_vram_loader.sv
// tb_vram_loader: randomized packet stimulus checked against a behavioural VRAM write/event model
module tb_vram_loader;
  localparam int DEPTH = 30000;
  localparam int TMO = 300;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ack, wr_en, busy, pkt_done, pkt_err;
  logic [14:0] wr_addr;
  logic [5:0] wr_data;
  logic [1:0] err_code;
  int total = 0, bad = 0, cyc = 0, last_ack = -100, last_wr = -100;
  int model_err = 0, fill_mode = 0, fill_seen = 0, pulses = 0;
  typedef struct {int a; int d;} wr_t;
  typedef struct {int code; int kind;} ev_t;
  wr_t wq[$];
  ev_t eq[$];
  int log_a[$], log_d[$], log_c[$];
  logic [7:0] fixed[$];
  vram_loader #(.VRAM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  task automatic exp_ev(input int code, input int kind);
    ev_t e;
    e.code = code;
    e.kind = kind;
    eq.push_back(e);
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (wr_en) begin
          log_a.push_back(int'(wr_addr));
          log_d.push_back(int'(wr_data));
          log_c.push_back(cyc);
          chk("wr_expected", wq.size() > 0, 1);
          if (wq.size() > 0) begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", wr_addr, w.a);
            chk("wr_data", wr_data, w.d);
          end
          if (fill_mode != 0 && fill_seen > 0) chk("fill_gap", cyc - last_wr, 1);
          if (fill_mode != 0) chk("fill_ack_low", rx_ack, 0);
          else chk("payload_latency", cyc - last_ack, 1);
          fill_seen++;
          last_wr = cyc;
        end
        if (pkt_done || pkt_err) begin
          pulses++;
          chk("ev_expected", eq.size() > 0, 1);
          chk("busy_at_end", busy, 0);
          chk("writes_before_end", wq.size(), 0);
          if (eq.size() > 0) begin
            ev_t e;
            e = eq.pop_front();
            chk("pkt_err", pkt_err, e.code != 0);
            chk("pkt_done", pkt_done, e.code == 0);
            if (e.code != 0) model_err = e.code;
            if (e.kind == 1) chk("end_after_ack", cyc - last_ack, 1);
            if (e.kind == 2) chk("done_after_wr", cyc - last_wr, 1);
            if (e.kind == 3) chk("tmo_window", (cyc - last_ack >= TMO) && (cyc - last_ack <= TMO + 4), 1);
          end
        end
        chk("err_code", err_code, model_err);
        if (rx_ack) last_ack = cyc;
      end
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ack && n < 400);
    chk("ack_seen", rx_ack, 1);
    @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic load(input int cmd, input logic [7:0] ah, input logic [7:0] al, input int len,
                      input bit corrupt, input bit no_tail);
    logic [7:0] body[$];
    logic [7:0] cs;
    int a;
    wr_t w;
    a = int'({ah[6:0], al});
    fill_mode = (cmd == 2) ? 1 : 0;
    fill_seen = 0;
    if (fixed.size() > 0) body = fixed;
    else if (len != 0)
      for (int i = 0; i < (cmd == 1 ? len : 1); i++)
        body.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom));
    fixed.delete();
    if (cmd != 1 && cmd != 2) begin
      exp_ev(1, 1);
      send(8'hA5);
      send(8'(cmd));
      return;
    end
    if (a >= DEPTH) exp_ev(2, 1);
    else begin
      for (int i = 0; i < len; i++) begin
        w.a = (a + i) % DEPTH;
        w.d = int'(body[cmd == 1 ? i : 0] & 8'h3F);
        wq.push_back(w);
      end
`ifdef VRAM_LOADER_CHECKSUM_EN
      exp_ev(corrupt ? 3 : 0, 1);
`else
      exp_ev(0, len == 0 ? 1 : 2);
`endif
    end
    cs = 8'(cmd) ^ ah ^ al ^ 8'(len >> 8) ^ 8'(len);
    foreach (body[i]) cs ^= body[i];
    send(8'hA5);
    send(8'(cmd));
    send(ah);
    send(al);
    send(8'(len >> 8));
    send(8'(len));
    if (a >= DEPTH || len == 0) body.delete();
    foreach (body[i]) send(body[i]);
`ifdef VRAM_LOADER_CHECKSUM_EN
    if (a < DEPTH && !no_tail) send(corrupt ? cs ^ 8'h5A : cs);
`else
    if (corrupt || no_tail) cs = 8'h00;
`endif
  endtask
  task automatic wait_end();
    int n = 0;
    while (eq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("end_in_time", eq.size(), 0);
    eq.delete();
    wq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic clear_log();
    log_a.delete();
    log_d.delete();
    log_c.delete();
  endtask
  task automatic chk_reset_outputs();
    chk("rst_rx_ack", rx_ack, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_err_code", err_code, 0);
  endtask
  initial begin
    int p0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    fixed = {8'h15, 8'h2A, 8'h3F};
    load(1, 8'h00, 8'h10, 3, 0, 0);
    wait_end();
    chk("w_count", log_a.size(), 3);
    if (log_a.size() == 3) begin
      chk("w_a0", log_a[0], 16'h10);
      chk("w_a1", log_a[1], 16'h11);
      chk("w_a2", log_a[2], 16'h12);
      chk("w_d0", log_d[0], 8'h15);
      chk("w_d1", log_d[1], 8'h2A);
      chk("w_d2", log_d[2], 8'h3F);
    end
    clear_log();
    fixed = {8'h07};
    load(2, 8'h75, 8'h2E, 4, 0, 0);
    wait_end();
    chk("f_count", log_a.size(), 4);
    if (log_a.size() == 4) begin
      chk("f_a0", log_a[0], 29998);
      chk("f_a1", log_a[1], 29999);
      chk("f_a2", log_a[2], 0);
      chk("f_a3", log_a[3], 1);
      for (int i = 0; i < 4; i++) chk("f_data", log_d[i], 7);
      chk("f_consecutive", log_c[3] - log_c[0], 3);
    end
    clear_log();
    load(3, 8'h00, 8'h00, 0, 0, 0);
    wait_end();
    chk("badcmd_nowrite", log_a.size(), 0);
    chk("badcmd_code", err_code, 1);
    load(1, 8'h75, 8'h30, 1, 0, 0);
    wait_end();
    chk("range_nowrite", log_a.size(), 0);
    chk("range_code", err_code, 2);
    fill_mode = 0;
    exp_ev(3, 3);
    send(8'hA5);
    send(8'h01);
    wait_end();
    chk("tmo_busy", busy, 0);
    chk("tmo_code", err_code, 3);
    chk("tmo_nowrite", log_a.size(), 0);
    fixed = {8'h01, 8'h02};
    load(1, 8'h00, 8'h40, 2, 0, 0);
    wait_end();
    chk("after_tmo_writes", log_a.size(), 2);
`ifdef VRAM_LOADER_CHECKSUM_EN
    clear_log();
    load(1, 8'h01, 8'h00, 5, 1, 0);
    wait_end();
    chk("csum_writes_kept", log_a.size(), 5);
    chk("csum_code", err_code, 3);
`endif
    clear_log();
    load(2, 8'h01, 8'h00, 100, 0, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("fill_active", wr_en, 1);
    #2 rst_n = 1'b0;
    model_err = 0;
    #1 chk_reset_outputs();
    wq.delete();
    eq.delete();
    p0 = pulses;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    chk("post_rst_nowrite", log_a.size(), 0);
    chk("post_rst_nopulse", pulses - p0, 0);
    chk("post_rst_idle", busy, 0);
    load(1, 8'h00, 8'h05, 4, 0, 0);
    wait_end();
    chk("post_rst_pkt", log_a.size(), 4);
    for (int k = 0; k < 30; k++) begin
      int c, ln, a, r;
      logic [7:0] ah, al;
      repeat ($urandom_range(0, 2)) send(8'($urandom_range(0, 8'hA4)));
      r = $urandom_range(0, 9);
      c = (r == 0) ? 3 + 60 * $urandom_range(0, 3) : (r < 5 ? 1 : 2);
      ln = $urandom_range(0, 12);
      r = $urandom_range(0, 9);
      a = (r == 0) ? $urandom_range(DEPTH, 32767) : (r == 1) ? DEPTH - 1 - $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1);
      ah = {1'($urandom), 7'(a >> 8)};
      al = 8'(a);
      load(c, ah, al, ln, $urandom_range(0, 3) == 0, 0);
      wait_end();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
